// File: rtl/card_sprite_renderer_if.sv
// Raster-in / pixel-out / card-RAM bus of the card sprite renderer.
// The renderer takes the slave side; the raster source, RAM and pixel sink take the master side.
interface card_sprite_renderer_if;
    logic       pix_valid;
    logic [8:0] hcount;
    logic [8:0] vcount;
    logic [2:0] bg_color;
    logic       frame_start;
    logic [7:0] pos_x;
    logic [7:0] pos_y;
    logic       card_en_in;
    logic       pos_load;
    logic       pos_pending;
    logic [8:0] rAddr;
    logic [2:0] rdData;
    logic       pix_out_valid;
    logic [2:0] pix_color;
    logic       pix_hit;

    modport slave (
        input  pix_valid, hcount, vcount, bg_color, frame_start,
               pos_x, pos_y, card_en_in, pos_load, rdData,
        output pos_pending, rAddr, pix_out_valid, pix_color, pix_hit
    );

    modport master (
        output pix_valid, hcount, vcount, bg_color, frame_start,
               pos_x, pos_y, card_en_in, pos_load, rdData,
        input  pos_pending, rAddr, pix_out_valid, pix_color, pix_hit
    );
endinterface

// File: rtl/card_sprite_renderer.sv
// Overlays a CARD_W x CARD_H sprite from a 1-cycle-latency card RAM onto the raster stream.
// Card position/enable are double-buffered and only switch over at frame start.
module card_sprite_renderer #(
    parameter int         CARD_W      = 16,
    parameter int         CARD_H      = 32,
    parameter logic [2:0] TRANSPARENT = 3'b000
) (
    input  logic                   clock,
    input  logic                   reset,
    card_sprite_renderer_if.slave  bus
);
    localparam logic [9:0] CARD_W_U = 10'(CARD_W);
    localparam logic [9:0] CARD_H_U = 10'(CARD_H);

    logic [7:0] pend_x, pend_y, act_x, act_y;
    logic       pend_en, act_en, pending;

    // Stage 0 geometry: zero-extended operands into a 10-bit signed difference, so a
    // pixel left of / above the card goes negative instead of wrapping into the box.
    logic signed [9:0] dx, dy;
    logic [9:0]        addr_full;
    logic              in_box;

    assign dx = signed'({1'b0, bus.hcount}) - signed'({2'b00, act_x});
    assign dy = signed'({1'b0, bus.vcount}) - signed'({2'b00, act_y});

    assign in_box = bus.pix_valid & act_en
                  & ~dx[9] & (unsigned'(dx) < CARD_W_U)
                  & ~dy[9] & (unsigned'(dy) < CARD_H_U);

    assign addr_full = unsigned'(dy) * CARD_W_U + unsigned'(dx);

    logic       v1, box1, v2, box2, hit_next;
    logic [2:0] bg1, bg2;

    assign hit_next = v2 & box2 & (bus.rdData != TRANSPARENT);

    // NOTE: every register here is assigned with <= so all stages read the values from
    // before the edge; blocking assignments would collapse the pipeline stages.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pend_x  <= '0;
            pend_y  <= '0;
            pend_en <= 1'b0;
            pending <= 1'b0;
            act_x   <= '0;
            act_y   <= '0;
            act_en  <= 1'b0;
        end else if (bus.frame_start && bus.pos_load) begin
            act_x   <= bus.pos_x;
            act_y   <= bus.pos_y;
            act_en  <= bus.card_en_in;
            pending <= 1'b0;
        end else if (bus.frame_start) begin
            if (pending) begin
                act_x  <= pend_x;
                act_y  <= pend_y;
                act_en <= pend_en;
            end
            pending <= 1'b0;
        end else if (bus.pos_load) begin
            pend_x  <= bus.pos_x;
            pend_y  <= bus.pos_y;
            pend_en <= bus.card_en_in;
            pending <= 1'b1;
        end
    end

    // NOTE: the valid bits are reset so a mid-frame reset flushes the pipe; the data
    // registers are reset too so outputs read 0 while reset is held.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            bus.rAddr         <= '0;
            v1                <= 1'b0;
            box1              <= 1'b0;
            bg1               <= '0;
            v2                <= 1'b0;
            box2              <= 1'b0;
            bg2               <= '0;
            bus.pix_out_valid <= 1'b0;
            bus.pix_hit       <= 1'b0;
            bus.pix_color     <= '0;
        end else begin
            if (in_box) bus.rAddr <= addr_full[8:0];
            v1                <= bus.pix_valid;
            box1              <= in_box;
            bg1               <= bus.bg_color;
            v2                <= v1;
            box2              <= box1;
            bg2               <= bg1;
            bus.pix_out_valid <= v2;
            bus.pix_hit       <= hit_next;
            bus.pix_color     <= hit_next ? bus.rdData : (v2 ? bg2 : 3'b000);
        end
    end

    assign bus.pos_pending = pending;
endmodule

// File: tb/tb_card_sprite_renderer.sv
// Directed bench for card_sprite_renderer with a 1-cycle-latency card RAM model.
// Expected values are hand-computed from the RAM contents written below.
module tb_card_sprite_renderer;
    logic clock = 1'b0;
    logic reset = 1'b1;
    int   n_cmp = 0;
    int   n_bad = 0;

    card_sprite_renderer_if bus ();

    card_sprite_renderer #(.CARD_W(16), .CARD_H(32), .TRANSPARENT(3'b000)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clock = ~clock;

    // RAM: word i holds i[2:0], except word 0 = 5, word 511 = 6, word 17 = transparent.
    logic [2:0] ram [512];
    always @(posedge clock) bus.rdData <= ram[bus.rAddr];

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [9:0] got, input logic [9:0] exp);
        n_cmp++;
        assert (got === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic load(input int x, input int y, input logic en, input logic fs);
        bus.pos_x       = 8'(x);
        bus.pos_y       = 8'(y);
        bus.card_en_in  = en;
        bus.pos_load    = 1'b1;
        bus.frame_start = fs;
        tick();
        bus.pos_load    = 1'b0;
        bus.frame_start = 1'b0;
    endtask

    task automatic fstart();
        bus.frame_start = 1'b1;
        tick();
        bus.frame_start = 1'b0;
    endtask

    // One isolated pixel: check rAddr after 1 edge, outputs after 2 more edges.
    task automatic pix(input string tag, input int h, input int v, input logic [2:0] bg,
                       input logic valid, input int e_addr, input logic e_ov,
                       input logic [2:0] e_col, input logic e_hit);
        bus.hcount    = 9'(h);
        bus.vcount    = 9'(v);
        bus.bg_color  = bg;
        bus.pix_valid = valid;
        tick();
        check({tag, " addr"}, 10'(bus.rAddr), 10'(e_addr));
        bus.pix_valid = 1'b0;
        bus.bg_color  = 3'b000;
        tick();
        tick();
        check({tag, " valid"}, 10'(bus.pix_out_valid), 10'(e_ov));
        check({tag, " color"}, 10'(bus.pix_color), 10'(e_col));
        check({tag, " hit"}, 10'(bus.pix_hit), 10'(e_hit));
    endtask

    initial begin
        for (int i = 0; i < 512; i++) ram[i] = 3'(i);
        ram[0]   = 3'd5;
        ram[511] = 3'd6;
        ram[17]  = 3'd0;

        bus.pix_valid = 0; bus.hcount = 0; bus.vcount = 0; bus.bg_color = 0;
        bus.frame_start = 0; bus.pos_x = 0; bus.pos_y = 0; bus.card_en_in = 0;
        bus.pos_load = 0;

        tick();
        tick();
        check("rst rAddr", 10'(bus.rAddr), 10'd0);
        check("rst valid", 10'(bus.pix_out_valid), 10'd0);
        check("rst color", 10'(bus.pix_color), 10'd0);
        check("rst hit", 10'(bus.pix_hit), 10'd0);
        check("rst pending", 10'(bus.pos_pending), 10'd0);
        reset = 1'b0;
        tick();

        load(10, 20, 1'b1, 1'b0);
        check("load pending", 10'(bus.pos_pending), 10'd1);
        fstart();
        check("fs pending", 10'(bus.pos_pending), 10'd0);

        pix("p10_20",   10, 20, 3'd2, 1'b1,   0, 1'b1, 3'd5, 1'b1);
        pix("p25_51",   25, 51, 3'd2, 1'b1, 511, 1'b1, 3'd6, 1'b1);
        pix("p26_51",   26, 51, 3'd4, 1'b1, 511, 1'b1, 3'd4, 1'b0);
        pix("transp",   11, 21, 3'd3, 1'b1,  17, 1'b1, 3'd3, 1'b0);

        load(100, 100, 1'b1, 1'b0);
        check("midframe pending", 10'(bus.pos_pending), 10'd1);
        pix("old pos",  10, 20, 3'd2, 1'b1,   0, 1'b1, 3'd5, 1'b1);
        pix("new early", 100, 100, 3'd1, 1'b1, 0, 1'b1, 3'd1, 1'b0);
        fstart();
        check("applied pending", 10'(bus.pos_pending), 10'd0);
        pix("new pos",  100, 100, 3'd1, 1'b1,   0, 1'b1, 3'd5, 1'b1);
        pix("new corner", 115, 131, 3'd1, 1'b1, 511, 1'b1, 3'd6, 1'b0 | 1'b1);
        pix("old gone", 10, 20, 3'd2, 1'b1, 511, 1'b1, 3'd2, 1'b0);

        load(5, 5, 1'b1, 1'b1);
        check("same-cycle pending", 10'(bus.pos_pending), 10'd0);
        pix("p5_5",     5, 5, 3'd2, 1'b1,   0, 1'b1, 3'd5, 1'b1);
        pix("p6_6",     6, 6, 3'd7, 1'b1,  17, 1'b1, 3'd7, 1'b0);

        load(50, 50, 1'b1, 1'b0);
        load(60, 60, 1'b1, 1'b0);
        check("lww pending", 10'(bus.pos_pending), 10'd1);
        fstart();
        pix("lww stale", 50, 50, 3'd3, 1'b1,  17, 1'b1, 3'd3, 1'b0);
        pix("lww new",   60, 60, 3'd3, 1'b1,   0, 1'b1, 3'd5, 1'b1);
        pix("invalid",   61, 60, 3'd5, 1'b0,   0, 1'b0, 3'd0, 1'b0);

        load(60, 60, 1'b0, 1'b1);
        pix("disabled",  61, 60, 3'd6, 1'b1,   0, 1'b1, 3'd6, 1'b0);

        // Right-edge clipping: card at x=250 shows only columns 250..255, no wrap to 0..5.
        load(250, 0, 1'b1, 1'b1);
        pix("clip h248", 248, 0, 3'd2, 1'b1, 0, 1'b1, 3'd2, 1'b0);
        pix("clip h249", 249, 0, 3'd2, 1'b1, 0, 1'b1, 3'd2, 1'b0);
        pix("clip h250", 250, 0, 3'd2, 1'b1, 0, 1'b1, 3'd5, 1'b1);
        pix("clip h251", 251, 0, 3'd2, 1'b1, 1, 1'b1, 3'd1, 1'b1);
        pix("clip h252", 252, 0, 3'd2, 1'b1, 2, 1'b1, 3'd2, 1'b1);
        pix("clip h253", 253, 0, 3'd2, 1'b1, 3, 1'b1, 3'd3, 1'b1);
        pix("clip h254", 254, 0, 3'd2, 1'b1, 4, 1'b1, 3'd4, 1'b1);
        pix("clip h255", 255, 0, 3'd2, 1'b1, 5, 1'b1, 3'd5, 1'b1);
        for (int h = 0; h < 6; h++)
            pix($sformatf("nowrap h%0d", h), h, 0, 3'd2, 1'b1, 5, 1'b1, 3'd2, 1'b0);

        // Streaming then mid-frame reset.
        load(10, 20, 1'b1, 1'b1);
        bus.pix_valid = 1'b1;
        bus.vcount    = 9'd20;
        bus.bg_color  = 3'd6;
        bus.hcount = 9'd10; tick();
        bus.hcount = 9'd11; tick();
        bus.hcount = 9'd12; tick();
        check("stream addr", 10'(bus.rAddr), 10'd2);
        check("stream valid", 10'(bus.pix_out_valid), 10'd1);
        check("stream color", 10'(bus.pix_color), 10'd5);
        check("stream hit", 10'(bus.pix_hit), 10'd1);
        bus.hcount = 9'd13;
        reset = 1'b1;
        #1;
        check("mid rst rAddr", 10'(bus.rAddr), 10'd0);
        check("mid rst valid", 10'(bus.pix_out_valid), 10'd0);
        check("mid rst color", 10'(bus.pix_color), 10'd0);
        check("mid rst hit", 10'(bus.pix_hit), 10'd0);
        tick();
        reset = 1'b0;
        tick();
        check("post rst e1 valid", 10'(bus.pix_out_valid), 10'd0);
        check("post rst e1 color", 10'(bus.pix_color), 10'd0);
        tick();
        check("post rst e2 valid", 10'(bus.pix_out_valid), 10'd0);
        tick();
        check("post rst e3 valid", 10'(bus.pix_out_valid), 10'd1);
        check("post rst e3 color", 10'(bus.pix_color), 10'd6);
        check("post rst e3 hit", 10'(bus.pix_hit), 10'd0);
        check("post rst rAddr", 10'(bus.rAddr), 10'd0);
        bus.pix_valid = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/card_sprite_renderer.md
Name: card_sprite_renderer

Overview:
- Downstream consumer of the 512x3-bit card image RAM, inside the 256x240 VGA pixel path.
- Takes the raster pixel stream (hcount/vcount with a valid strobe) and drives the RAM read address.
- Merges the 1-cycle-latency RAM read data with a background colour and emits a pipelined 3-bit pixel.
- Card position and enable are double-buffered and only take effect at frame start, so the card never tears mid-frame.

Parameters:
- CARD_W, 16, card width in pixels; power of two; CARD_W*CARD_H must be <= 512.
- CARD_H, 32, card height in pixels.
- TRANSPARENT, 3'b000, RAM colour code treated as see-through.

Ports:
- clock  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high reset
- pix_valid  in  1  current hcount/vcount is a visible pixel
- hcount  in  9  pixel column, 0..255 visible
- vcount  in  9  pixel row, 0..239 visible
- bg_color  in  3  background colour for this pixel
- frame_start  in  1  single-cycle pulse at start of frame
- pos_x  in  8  requested card left edge
- pos_y  in  8  requested card top edge
- card_en_in  in  1  requested card visibility
- pos_load  in  1  capture pos_x/pos_y/card_en_in into pending
- pos_pending  out  1  pending update not yet applied
- rAddr  out  9  card RAM read address (registered)
- rdData  in  3  card RAM dataOut; valid one edge after rAddr is sampled
- pix_out_valid  out  1  pix_color is valid
- pix_color  out  3  final pixel colour
- pix_hit  out  1  pixel came from an opaque card texel

Behaviour:
- Reset (async, while high): rAddr=0, pix_out_valid=0, pix_color=0, pix_hit=0, pos_pending=0; active pos=(0,0), active enable=0; all pipeline valid bits 0.
- Mid-frame reset flushes the pipeline; no stale pixel may appear after release.
- Position buffering:
  - pos_load at an edge copies pos_x, pos_y and card_en_in into pending and sets pos_pending=1.
  - A later pos_load before frame_start overwrites pending (last write wins).
  - frame_start with pos_pending=1 copies pending to active and clears pos_pending.
  - frame_start with pos_pending=0 leaves active unchanged.
  - pos_load and frame_start in the same cycle: the new inputs go straight to active and pos_pending=0.
- Stage 0, at the edge sampling inputs:
  - dx = hcount - pos_x and dy = vcount - pos_y, computed 10-bit signed with zero-extended operands; there is no wrap-around.
  - in_box = pix_valid & active_en & 0<=dx<CARD_W & 0<=dy<CARD_H.
  - If in_box, rAddr <= dy*CARD_W + dx; otherwise rAddr holds its value.
  - Register v1=pix_valid, box1=in_box, bg1=bg_color.
- Stage 1: the RAM samples rAddr. The renderer registers v2=v1, box2=box1, bg2=bg1.
- Stage 2:
  - pix_out_valid <= v2.
  - pix_hit <= v2 & box2 & (rdData != TRANSPARENT).
  - pix_color <= pix_hit_next ? rdData : (v2 ? bg2 : 0).
- Latency: inputs sampled at edge k appear on the outputs after edge k+2. Fully pipelined, one pixel per clock, no stalls.
- Clipping: a card extending past column 255 or row 239 is drawn only where pix_valid=1. A pos_x near 255 yields only a partial card, never a wrapped one.
- pix_valid=0 always yields pix_out_valid=0 and pix_color=0, two edges later.

Test Plan:
- Reset, then load pos=(10,20) with en=1, pulse frame_start. Drive hcount=10, vcount=20, valid. Expect rAddr=0 after 1 edge; RAM word 0=3'b101 gives pix_color=5, pix_hit=1 after 2 edges.
- Same card, pixel (25,51). Expect rAddr=31*16+15=511, and output equal to RAM[511]. Pixel (26,51) must output bg_color with pix_hit=0.
- RAM texel = TRANSPARENT, bg_color=3'b011: pix_color=3, pix_hit=0, pix_out_valid=1.
- pos_load (100,100) mid-frame without frame_start: the card still renders at (10,20) and pos_pending=1. After frame_start it renders at (100,100) and pos_pending=0. Then assert pos_load and frame_start in the same cycle with (5,5): active=(5,5), pos_pending=0.
- pos_x=250, pixels hcount 248..255: hits only at 250..255, with rAddr dx=0..5; hcount 0..5 must not hit.
- Stream 4 valid pixels, assert reset on the 3rd edge: all outputs go 0 immediately, no valid output for 2 edges after release, and active en=0 so no hits.
